// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal operand width range.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic logic width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, WIDTH steps per operation,
// registered result with sum, carry-out, signed overflow and a done pulse.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] ps_q, ps_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_sum;
  logic             cell_co;
  logic             c_msb;
  logic [WIDTH-1:0] ps_full;

  fa_cell u_fa (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .ci  (c_q),
    .sum (cell_sum),
    .co  (cell_co)
  );

  // On the MSB step the carry register still holds the carry into the MSB.
  assign c_msb   = c_q;
  assign ps_full = {cell_sum, ps_q};

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d = 1'b0;
        if (start) begin
          // Subtraction is a + ~b + 1, so the carry seeds the +1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = cell_co;
        ps_d  = ps_full[WIDTH-1:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          s_d     = ps_full;
          cout_d  = cell_co;
          ovf_d   = c_msb ^ cell_co;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are reset too, so an abandoned operation
  // leaves no stale operand bits and reset state is fully defined.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge values computed by the always_comb block.
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      ps_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a transaction-level model checked every
// cycle on the WIDTH=8 instance, plus directed vectors on WIDTH=8, 2 and 32.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;

  logic       start2, sub2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] s2;

  logic        start32, sub32, cin32;
  logic [31:0] a32, b32;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] s32;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: unsigned result/carry and signed range overflow.
  function automatic void model8(input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic sb,
                                 output logic [7:0] rs, output logic rc, output logic ro);
    logic [8:0] full;
    int         sv;
    if (sb) begin
      rs = a - b;
      rc = (a >= b);
      sv = int'($signed(a)) - int'($signed(b));
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      rs   = full[7:0];
      rc   = full[8];
      sv   = int'($signed(a)) + int'($signed(b)) + int'(ci);
    end
    ro = (sv > 127) || (sv < -128);
  endfunction

  // Transaction model: an accepted start yields a result WIDTH edges later.
  int         m_rem = 0;
  logic       m_armed = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_s = '0, p_s;
  logic       m_c = 1'b0, m_o = 1'b0, p_c, p_o;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_rem = 0; m_s = '0; m_c = 1'b0; m_o = 1'b0; m_armed = 1'b1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1; m_s = p_s; m_c = p_c; m_o = p_o;
      end
    end else if (start8) begin
      model8(a8, b8, cin8, sub8, p_s, p_c, p_o);
      m_rem = 8;
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("cyc_busy", {63'd0, busy8}, {63'd0, m_rem > 0});
      check("cyc_done", {63'd0, done8}, {63'd0, m_done});
      check("cyc_s",    {56'd0, s8},    {56'd0, m_s});
      check("cyc_cout", {63'd0, cout8}, {63'd0, m_c});
      check("cyc_ovf",  {63'd0, ovf8},  {63'd0, m_o});
    end
  end

  task automatic wait_done8(output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb,
                        input logic [7:0] es, input logic ec, input logic eo);
    int   lat;
    logic seen;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    wait_done8(lat, seen);
    check({nm, "_seen"}, {63'd0, seen}, 64'd1);
    check({nm, "_lat"},  64'(lat), 64'd8);
    check({nm, "_s"},    {56'd0, s8}, {56'd0, es});
    check({nm, "_cout"}, {63'd0, cout8}, {63'd0, ec});
    check({nm, "_ovf"},  {63'd0, ovf8}, {63'd0, eo});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic seen;
    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start2 = 0; sub2 = 0; cin2 = 0; a2 = 0; b2 = 0;
    start32 = 0; sub32 = 0; cin32 = 0; a32 = 0; b32 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_s",    {56'd0, s8},    64'd0);

    run_op("add_basic", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
    run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_cin",   8'h10, 8'h0F, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
    run_op("sub_neg",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_neg_c", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf_c", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Reset mid-RUN after three bit-steps; prior result 0x7F must clear.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; sub8 = 0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy8}, 64'd0);
    check("midrst_done", {63'd0, done8}, 64'd0);
    check("midrst_s",    {56'd0, s8},    64'd0);
    check("midrst_cout", {63'd0, cout8}, 64'd0);
    check("midrst_ovf",  {63'd0, ovf8},  64'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", {63'd0, done8}, 64'd0);
    end
    run_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    check("rst_prio_busy", {63'd0, busy8}, 64'd0);

    // start held through RUN with changing operands: only the first are used.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h05; cin8 = 0; sub8 = 0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
      else begin
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    check("hold_seen", {63'd0, seen}, 64'd1);
    check("hold_lat",  64'(lat), 64'd8);
    check("hold_s",    {56'd0, s8}, 64'h41);

    // Back-to-back: start during the DONE cycle; next done 9 cycles later.
    @(posedge clk); #1;
    a8 = 8'h3C; b8 = 8'h05; cin8 = 0; sub8 = 0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat, seen);
    check("b2b_first_seen", {63'd0, seen}, 64'd1);
    a8 = 8'h11; b8 = 8'h22; cin8 = 0; sub8 = 0; start8 = 1'b1;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      lat++;
      if (done8) seen = 1'b1;
      else if (busy8) check("b2b_s_stable", {56'd0, s8}, 64'h41);
    end
    check("b2b_seen", {63'd0, seen}, 64'd1);
    check("b2b_lat",  64'(lat), 64'd9);
    check("b2b_s",    {56'd0, s8}, 64'h33);

    // WIDTH=2 corner: 3 + 1 + cin 1.
    @(negedge clk);
    a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done2) seen = 1'b1;
    end
    check("w2_seen", {63'd0, seen}, 64'd1);
    check("w2_lat",  64'(lat), 64'd2);
    check("w2_s",    {62'd0, s2}, 64'd1);
    check("w2_cout", {63'd0, cout2}, 64'd1);
    check("w2_ovf",  {63'd0, ovf2}, 64'd0);
    check("w2_busy", {63'd0, busy2}, 64'd0);

    // WIDTH=32 corner: all-ones + 0 + cin 1.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; sub32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done32) seen = 1'b1;
    end
    check("w32_seen", {63'd0, seen}, 64'd1);
    check("w32_lat",  64'(lat), 64'd32);
    check("w32_s",    {32'd0, s32}, 64'd0);
    check("w32_cout", {63'd0, cout32}, 64'd1);
    check("w32_ovf",  {63'd0, ovf32}, 64'd0);
    check("w32_busy", {63'd0, busy32}, 64'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
